// File: rtl/alu_hs.sv
// alu_hs: registered ALU with valid/ready handshakes on both sides.
// Single-cycle ops return one cycle after accept. Results and flags are
// held until the consumer takes them.
// Optional feature macro: ALU_HS_MUL_EN adds an iterative unsigned
// shift-add multiply on opcode 4'b1000. Without the macro, 4'b1000 is
// treated as illegal.
module alu_hs #(
  parameter int WIDTH      = 4,
  parameter int CMP_SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_cf,
  output logic             out_of,
  output logic             out_zf,
  output logic             out_nf,
  output logic             out_err
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_NOT = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SLT = 4'b0110;
  localparam logic [3:0] OP_EQ  = 4'b0111;
`ifdef ALU_HS_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             accept_s;
  logic             load_s;
  logic             is_mul_s;
  logic [WIDTH-1:0] res_s;
  logic             cf_s;
  logic             of_s;
  logic             err_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic             lt_s;
  logic             last_s;

  logic [WIDTH-1:0] res_r;
  logic             cf_r;
  logic             of_r;
  logic             zf_r;
  logic             nf_r;
  logic             err_r;
  logic             valid_r;

  // Adder/subtractor share the carry-out convention: SUB carry means no borrow.
  assign sum_s  = {1'b0, in_a} + {1'b0, in_b};
  assign diff_s = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};
  assign lt_s   = (CMP_SIGNED != 0) ? ($signed(in_a) < $signed(in_b)) : (in_a < in_b);

  // Ready is combinational on out_ready so a pop and a new accept share a cycle.
  assign in_ready = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
  assign accept_s = in_valid && in_ready;

`ifdef ALU_HS_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] prod_r;
  logic [2*WIDTH-1:0] prod_nxt_s;
  logic [WIDTH-1:0]   mcand_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH:0]     part_s;

  // One shift-add step: add multiplicand into the high half when the
  // multiplier LSB (held in the low half) is set, then shift right.
  assign part_s     = {1'b0, prod_r[2*WIDTH-1:WIDTH]}
                    + {1'b0, (prod_r[0] ? mcand_r : {WIDTH{1'b0}})};
  assign prod_nxt_s = {part_s, prod_r[WIDTH-1:1]};
  assign last_s     = (cnt_r == CW'(WIDTH - 1));

  // Multiply datapath: load operands on accept, step while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r  <= {(2*WIDTH){1'b0}};
      mcand_r <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else if (accept_s && is_mul_s) begin
      prod_r  <= {{WIDTH{1'b0}}, in_b};
      mcand_r <= in_a;
      cnt_r   <= {CW{1'b0}};
    end else if (state_r == ST_BUSY) begin
      prod_r  <= prod_nxt_s;
      cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      prod_r  <= prod_r;
      mcand_r <= mcand_r;
      cnt_r   <= cnt_r;
    end
  end
`else
  assign last_s = 1'b0;
`endif

  // Single-cycle result and flag computation from the offered operands.
  always_comb begin
    res_s    = {WIDTH{1'b0}};
    cf_s     = 1'b0;
    of_s     = 1'b0;
    err_s    = 1'b0;
    is_mul_s = 1'b0;
    case (in_op)
      OP_ADD: begin
        res_s = sum_s[WIDTH-1:0];
        cf_s  = sum_s[WIDTH];
        of_s  = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum_s[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        res_s = diff_s[WIDTH-1:0];
        cf_s  = diff_s[WIDTH];
        of_s  = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff_s[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_NOT: res_s = ~in_a;
      OP_AND: res_s = in_a & in_b;
      OP_OR:  res_s = in_a | in_b;
      OP_XOR: res_s = in_a ^ in_b;
      OP_SLT: res_s = {{(WIDTH-1){1'b0}}, lt_s};
      OP_EQ:  res_s = {{(WIDTH-1){1'b0}}, (in_a == in_b)};
`ifdef ALU_HS_MUL_EN
      OP_MUL: is_mul_s = 1'b1;
`endif
      default: err_s = 1'b1;
    endcase
  end

  // Next-state logic; load_s marks a single-cycle result being captured.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (is_mul_s) begin
            state_nxt_s = ST_BUSY;
          end else begin
            state_nxt_s = ST_DONE;
            load_s      = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (!out_ready) begin
          state_nxt_s = ST_DONE;
        end else if (!accept_s) begin
          state_nxt_s = ST_IDLE;
        end else if (is_mul_s) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_DONE;
          load_s      = 1'b1;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output registers: captured on entry to DONE, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_r   <= {WIDTH{1'b0}};
      cf_r    <= 1'b0;
      of_r    <= 1'b0;
      zf_r    <= 1'b0;
      nf_r    <= 1'b0;
      err_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= (state_nxt_s == ST_DONE);
      if (load_s) begin
        res_r <= res_s;
        cf_r  <= cf_s;
        of_r  <= of_s;
        zf_r  <= (res_s == {WIDTH{1'b0}});
        nf_r  <= res_s[WIDTH-1];
        err_r <= err_s;
`ifdef ALU_HS_MUL_EN
      end else if ((state_r == ST_BUSY) && last_s) begin
        res_r <= prod_nxt_s[WIDTH-1:0];
        cf_r  <= |prod_nxt_s[2*WIDTH-1:WIDTH];
        of_r  <= 1'b0;
        zf_r  <= (prod_nxt_s[WIDTH-1:0] == {WIDTH{1'b0}});
        nf_r  <= prod_nxt_s[WIDTH-1];
        err_r <= 1'b0;
`endif
      end else begin
        res_r <= res_r;
        cf_r  <= cf_r;
        of_r  <= of_r;
        zf_r  <= zf_r;
        nf_r  <= nf_r;
        err_r <= err_r;
      end
    end
  end

  assign out_valid = valid_r;
  assign out_res   = res_r;
  assign out_cf    = cf_r;
  assign out_of    = of_r;
  assign out_zf    = zf_r;
  assign out_nf    = nf_r;
  assign out_err   = err_r;

endmodule

// File: tb/tb_alu_hs.sv
// Directed self-checking bench for alu_hs (WIDTH=4). A second instance with
// CMP_SIGNED=0 shares all inputs and is checked on the unsigned SLT case.
module tb_alu_hs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_res;
  logic       out_cf, out_of, out_zf, out_nf, out_err;

  logic       u_in_ready, u_out_valid;
  logic [3:0] u_out_res;
  logic       u_cf, u_of, u_zf, u_nf, u_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_hs #(.WIDTH(4), .CMP_SIGNED(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .out_cf(out_cf), .out_of(out_of),
    .out_zf(out_zf), .out_nf(out_nf), .out_err(out_err)
  );

  alu_hs #(.WIDTH(4), .CMP_SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(u_out_valid),
    .out_ready(out_ready), .out_res(u_out_res), .out_cf(u_cf), .out_of(u_of),
    .out_zf(u_zf), .out_nf(u_nf), .out_err(u_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // flags packed as {cf, of, zf, nf, err}
  task automatic chk_out(input string tag, input logic [3:0] res, input logic [4:0] flags);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_res"}, {28'd0, out_res}, {28'd0, res});
    chk({tag, "_flags"}, {27'd0, out_cf, out_of, out_zf, out_nf, out_err}, {27'd0, flags});
  endtask

  // Offer one op on the falling edge; returns #1 after the accepting rising edge.
  task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 4'h0;
    in_a      = 4'h0;
    in_b      = 4'h0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_res", {28'd0, out_res}, 32'd0);
    chk("rst_flags", {27'd0, out_cf, out_of, out_zf, out_nf, out_err}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    // ADD 7+1: valid must be low before the accept edge, high one cycle after
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'b0000; in_a = 4'h7; in_b = 4'h1;
    chk("add_pre_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_out("add_7_1", 4'h8, 5'b01010);

    // back-to-back ops, out_ready high: one per cycle
    issue(4'b0001, 4'h3, 4'h5); chk_out("sub_3_5", 4'hE, 5'b00010);
    issue(4'b0001, 4'h5, 4'h3); chk_out("sub_5_3", 4'h2, 5'b10000);
    issue(4'b0001, 4'h8, 4'h1); chk_out("sub_8_1", 4'h7, 5'b11000);
    issue(4'b0000, 4'hF, 4'h1); chk_out("add_f_1", 4'h0, 5'b10100);
    issue(4'b0110, 4'h8, 4'h7); chk_out("slt_s_8_7", 4'h1, 5'b00000);
    chk("slt_u_8_7", {28'd0, u_out_res}, 32'd0);
    issue(4'b0111, 4'hA, 4'hA); chk_out("eq_a_a", 4'h1, 5'b00000);
    issue(4'b0111, 4'hA, 4'hB); chk_out("eq_a_b", 4'h0, 5'b00100);
    issue(4'b0010, 4'h5, 4'h0); chk_out("not_5", 4'hA, 5'b00010);
    issue(4'b0011, 4'hC, 4'hA); chk_out("and_c_a", 4'h8, 5'b00010);
    issue(4'b0100, 4'h5, 4'h2); chk_out("or_5_2", 4'h7, 5'b00000);
    issue(4'b0101, 4'hF, 4'hF); chk_out("xor_f_f", 4'h0, 5'b00100);
    issue(4'b1111, 4'h3, 4'h3); chk_out("illegal_f", 4'h0, 5'b00101);

`ifdef ALU_HS_MUL_EN
    issue(4'b1000, 4'h5, 4'h3);
    chk("mul_busy_ready", {31'd0, in_ready}, 32'd0);
    chk("mul_busy_valid", {31'd0, out_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("mul_lat4_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk_out("mul_5_3", 4'hF, 5'b00010);
    @(posedge clk);
    #1;
    issue(4'b1000, 4'h9, 4'h2);
    repeat (4) @(posedge clk);
    #1;
    chk_out("mul_9_2", 4'h2, 5'b10000);
`else
    issue(4'b1000, 4'h5, 4'h3); chk_out("mul_off", 4'h0, 5'b00101);
`endif
    @(posedge clk);
    #1;
    chk("idle_valid", {31'd0, out_valid}, 32'd0);

    // backpressure: result held for 3 cycles while a new op is offered
    @(negedge clk);
    out_ready = 1'b0;
    issue(4'b0000, 4'h2, 4'h3);
    chk_out("bp_first", 4'h5, 5'b00000);
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'b0011; in_a = 4'hF; in_b = 4'h3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      chk_out("bp_hold", 4'h5, 5'b00000);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_comb_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_out("bp_second", 4'h3, 5'b00000);
    @(posedge clk);
    #1;
    chk("bp_popped", {31'd0, out_valid}, 32'd0);

    // asynchronous reset two cycles into a multiply (held result if MUL is off)
    @(negedge clk);
    out_ready = 1'b0;
    issue(4'b1000, 4'h5, 4'h3);
    repeat (2) @(posedge clk);
    #3;
`ifdef ALU_HS_MUL_EN
    chk("rst_mid_pre_ready", {31'd0, in_ready}, 32'd0);
`else
    chk("rst_mid_pre_valid", {31'd0, out_valid}, 32'd1);
`endif
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_err", {31'd0, out_err}, 32'd0);
    chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    issue(4'b0000, 4'h1, 4'h1);
    chk_out("post_rst_add", 4'h2, 5'b00000);
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
